// File: rtl/eei_dispatch_if.sv
// Bundle of core-side EEI signals and per-unit channel signals seen by eei_dispatch.
// master = core plus units (environment); slave = the dispatcher.
interface eei_dispatch_if #(
    parameter int NUM_CH = 4,
    parameter int RS_MAX = 2,
    parameter int RD_MAX = 4
);
    logic                                   eei_req;
    logic                                   eei_ext;
    logic [2:0]                             eei_funct3;
    logic [6:0]                             eei_funct7;
    logic [4:0]                             eei_batch_start;
    logic [4:0]                             eei_batch_len;
    logic [RS_MAX-1:0][31:0]                eei_rs_val;
    logic                                   eei_ack;
    logic                                   eei_error;
    logic [1:0]                             eei_rd_op;
    logic [4:0]                             eei_rd_len;
    logic [RD_MAX-1:0][31:0]                eei_rd_val;

    logic [NUM_CH-1:0]                      ch_req;
    logic [6:0]                             ch_funct7;
    logic [4:0]                             ch_batch_start;
    logic [4:0]                             ch_batch_len;
    logic [RS_MAX-1:0][31:0]                ch_rs_val;
    logic [NUM_CH-1:0]                      ch_ack;
    logic [NUM_CH-1:0]                      ch_error;
    logic [NUM_CH-1:0][1:0]                 ch_rd_op;
    logic [NUM_CH-1:0][4:0]                 ch_rd_len;
    logic [NUM_CH-1:0][RD_MAX-1:0][31:0]    ch_rd_val;

    // Handshake: eei_req is held by the core until eei_ack (a one-cycle strobe) is
    // sampled; ch_req[i] is held by the dispatcher until ch_ack[i] is sampled high.
    modport master (
        output eei_req, eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len,
               eei_rs_val, ch_ack, ch_error, ch_rd_op, ch_rd_len, ch_rd_val,
        input  eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val,
               ch_req, ch_funct7, ch_batch_start, ch_batch_len, ch_rs_val
    );

    modport slave (
        input  eei_req, eei_ext, eei_funct3, eei_funct7, eei_batch_start, eei_batch_len,
               eei_rs_val, ch_ack, ch_error, ch_rd_op, ch_rd_len, ch_rd_val,
        output eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val,
               ch_req, ch_funct7, ch_batch_start, ch_batch_len, ch_rs_val
    );
endinterface

// File: rtl/eei_dispatch.sv
// EEI dispatcher: decodes {eei_ext,eei_funct3} to one of NUM_CH units and runs a registered
// req/ack exchange. Optional busy timeout is enabled by defining SOPHON_EEI_TIMEOUT_EN.
module eei_dispatch #(
    parameter int NUM_CH  = 4,
    parameter int RS_MAX  = 2,
    parameter int RD_MAX  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    eei_dispatch_if.slave bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t state, state_nxt;

    logic [3:0]              idx;
    logic                    unmapped;
    logic                    ack_sel;
    logic                    timeout;
    logic                    sel_err;
    logic [1:0]              sel_op;
    logic [4:0]              sel_len;
    logic [RD_MAX-1:0][31:0] sel_val;
    logic                    bad;

    logic                    ack_d, err_d;
    logic [1:0]              op_d;
    logic [4:0]              len_d;
    logic [RD_MAX-1:0][31:0] val_d;
    logic [NUM_CH-1:0]       req_d;
    logic [6:0]              f7_d;
    logic [4:0]              bs_d, bl_d;
    logic [RS_MAX-1:0][31:0] rs_d;

    assign idx       = {bus.eei_ext, bus.eei_funct3};
    assign unmapped  = int'(idx) >= NUM_CH;
    // ch_req is one-hot on the active channel while BUSY, so it doubles as the response select.
    assign ack_sel   = |(bus.ch_ack & bus.ch_req);
    assign dbg_state = state;

`ifdef SOPHON_EEI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] busy_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)            busy_cnt <= '0;
        else if (state != BUSY) busy_cnt <= '0;
        else                    busy_cnt <= busy_cnt + CW'(1);
    end

    assign timeout = (state == BUSY) && (busy_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        sel_err = 1'b0;
        sel_op  = '0;
        sel_len = '0;
        sel_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.ch_req[c]) begin
                sel_err = bus.ch_error[c];
                sel_op  = bus.ch_rd_op[c];
                sel_len = bus.ch_rd_len[c];
                sel_val = bus.ch_rd_val[c];
            end
        end
    end

    assign bad = sel_err || (sel_op == 2'd3) ||
                 ((sel_op == 2'd2) && ((sel_len == 5'd0) || (int'(sel_len) > RD_MAX)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.eei_req) state_nxt = unmapped ? RESP : BUSY;
            BUSY:    if (ack_sel || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the output flops; result fields are non-zero only in the ack cycle.
    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
        op_d  = '0;
        len_d = '0;
        val_d = '0;
        req_d = bus.ch_req;
        f7_d  = bus.ch_funct7;
        bs_d  = bus.ch_batch_start;
        bl_d  = bus.ch_batch_len;
        rs_d  = bus.ch_rs_val;
        case (state)
            IDLE: begin
                if (bus.eei_req) begin
                    f7_d = bus.eei_funct7;
                    bs_d = bus.eei_batch_start;
                    bl_d = bus.eei_batch_len;
                    rs_d = bus.eei_rs_val;
                    if (unmapped) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        for (int c = 0; c < NUM_CH; c++) req_d[c] = (int'(idx) == c);
                    end
                end
            end
            BUSY: begin
                if (ack_sel) begin
                    ack_d = 1'b1;
                    req_d = '0;
                    if (bad) begin
                        err_d = 1'b1;
                    end else if (sel_op == 2'd1) begin
                        op_d     = 2'd1;
                        val_d[0] = sel_val[0];
                    end else if (sel_op == 2'd2) begin
                        op_d  = 2'd2;
                        len_d = sel_len;
                        for (int r = 0; r < RD_MAX; r++)
                            if (r < int'(sel_len)) val_d[r] = sel_val[r];
                    end
                end else if (timeout) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                    req_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.eei_ack        <= 1'b0;
            bus.eei_error      <= 1'b0;
            bus.eei_rd_op      <= '0;
            bus.eei_rd_len     <= '0;
            bus.eei_rd_val     <= '0;
            bus.ch_req         <= '0;
            bus.ch_funct7      <= '0;
            bus.ch_batch_start <= '0;
            bus.ch_batch_len   <= '0;
            bus.ch_rs_val      <= '0;
        end else begin
            bus.eei_ack        <= ack_d;
            bus.eei_error      <= err_d;
            bus.eei_rd_op      <= op_d;
            bus.eei_rd_len     <= len_d;
            bus.eei_rd_val     <= val_d;
            bus.ch_req         <= req_d;
            bus.ch_funct7      <= f7_d;
            bus.ch_batch_start <= bs_d;
            bus.ch_batch_len   <= bl_d;
            bus.ch_rs_val      <= rs_d;
        end
    end
endmodule

// File: tb/tb_eei_dispatch.sv
// Bench for eei_dispatch: directed cases plus random instructions against a rule-level model;
// the timeout case is exercised only when SOPHON_EEI_TIMEOUT_EN is defined.
module tb_eei_dispatch;
    localparam int NUM_CH = 4;
    localparam int RS_MAX = 2;
    localparam int RD_MAX = 4;
    localparam int TMO    = 8;
    localparam int RW     = 8 + 32 * RD_MAX;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];

    eei_dispatch_if #(.NUM_CH(NUM_CH), .RS_MAX(RS_MAX), .RD_MAX(RD_MAX)) bus ();

    eei_dispatch #(.NUM_CH(NUM_CH), .RS_MAX(RS_MAX), .RD_MAX(RD_MAX), .TIMEOUT(TMO)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected core response from the unit's raw answer, following the result rules.
    function automatic logic [RW-1:0] model(input bit mapped, input bit tmo, input bit uerr,
                                            input logic [1:0] op, input logic [4:0] len,
                                            input logic [RD_MAX-1:0][31:0] v);
        logic [RD_MAX-1:0][31:0] r;
        r = '0;
        if (!mapped || tmo || uerr || op == 2'd3) return {1'b1, 2'd0, 5'd0, r};
        if (op == 2'd2) begin
            if (len == 5'd0 || int'(len) > RD_MAX) return {1'b1, 2'd0, 5'd0, r};
            for (int i = 0; i < int'(len); i++) r[i] = v[i];
            return {1'b0, 2'd2, len, r};
        end
        if (op == 2'd1) begin
            r[0] = v[0];
            return {1'b0, 2'd1, 5'd0, r};
        end
        return {1'b0, 2'd0, 5'd0, r};
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (bus.eei_ack) begin
                if (exp_q.size() == 0) chk("unexpected_ack", RW'(1), RW'(0));
                else chk("response", {bus.eei_error, bus.eei_rd_op, bus.eei_rd_len, bus.eei_rd_val},
                         exp_q.pop_front());
            end else begin
                chk("idle_outputs_zero", {bus.eei_error, bus.eei_rd_op, bus.eei_rd_len, bus.eei_rd_val},
                    RW'(0));
            end
        end
    end

    task automatic stray_units();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.ch_ack[c]    = ($urandom_range(0, 3) == 0);
            bus.ch_error[c]  = 1'($urandom_range(0, 1));
            bus.ch_rd_op[c]  = 2'($urandom_range(0, 3));
            bus.ch_rd_len[c] = 5'($urandom_range(0, 31));
            for (int r = 0; r < RD_MAX; r++) bus.ch_rd_val[c][r] = $urandom;
        end
    endtask

    task automatic scramble_core();
        bus.eei_ext         = 1'($urandom_range(0, 1));
        bus.eei_funct3      = 3'($urandom_range(0, 7));
        bus.eei_funct7      = 7'($urandom_range(0, 127));
        bus.eei_batch_start = 5'($urandom_range(0, 31));
        bus.eei_batch_len   = 5'($urandom_range(0, 31));
        for (int i = 0; i < RS_MAX; i++) bus.eei_rs_val[i] = $urandom;
    endtask

    // Issue one instruction (called just after a rising edge) and play the addressed unit,
    // which answers in its d-th BUSY cycle (d=0: same cycle ch_req rises).
    task automatic run_instr(input logic [3:0] idx, input int d, input bit uerr, input logic [1:0] uop,
                             input logic [4:0] ulen, input logic [RD_MAX-1:0][31:0] uvals, input bit tmo);
        bit mapped;
        int exp_lat, exp_busy, lat, busy;
        bit seen;
        logic [6:0] f7;
        logic [4:0] bs, bl;
        logic [RS_MAX-1:0][31:0] rs;
        mapped   = int'(idx) < NUM_CH;
        exp_lat  = !mapped ? 1 : (tmo ? TMO + 1 : d + 2);
        exp_busy = !mapped ? 0 : (tmo ? TMO : d + 1);
        exp_q.push_back(model(mapped, tmo, uerr, uop, ulen, uvals));
        f7 = 7'($urandom_range(0, 127));
        bs = 5'($urandom_range(0, 31));
        bl = 5'($urandom_range(0, 31));
        for (int i = 0; i < RS_MAX; i++) rs[i] = $urandom;
        bus.eei_req         = 1'b1;
        bus.eei_ext         = idx[3];
        bus.eei_funct3      = idx[2:0];
        bus.eei_funct7      = f7;
        bus.eei_batch_start = bs;
        bus.eei_batch_len   = bl;
        bus.eei_rs_val      = rs;
        stray_units();
        if (mapped) bus.ch_ack[int'(idx)] = 1'b0;
        lat  = 0;
        busy = 0;
        seen = 1'b0;
        while (!seen && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            stray_units();
            if (mapped) bus.ch_ack[int'(idx)] = 1'b0;
            if (bus.eei_ack) begin
                seen = 1'b1;
            end else begin
                scramble_core();
                if (bus.ch_req != '0) begin
                    if (busy == 0) begin
                        chk("ch_req_onehot", RW'(bus.ch_req), RW'(1) << idx);
                        chk("ch_operands", RW'({bus.ch_funct7, bus.ch_batch_start, bus.ch_batch_len, bus.ch_rs_val}),
                            RW'({f7, bs, bl, rs}));
                    end
                    if (busy == d) begin
                        bus.ch_ack[int'(idx)]    = 1'b1;
                        bus.ch_error[int'(idx)]  = uerr;
                        bus.ch_rd_op[int'(idx)]  = uop;
                        bus.ch_rd_len[int'(idx)] = ulen;
                        bus.ch_rd_val[int'(idx)] = uvals;
                    end
                    busy++;
                end
            end
        end
        if (!seen) chk("ack_wait_expired", RW'(0), RW'(1));
        chk("latency", RW'(lat), RW'(exp_lat));
        chk("ch_req_cycles", RW'(busy), RW'(exp_busy));
        @(posedge clk);
        #1;
        chk("ack_one_cycle", RW'(bus.eei_ack), RW'(0));
        bus.eei_req = 1'b0;
        stray_units();
    endtask

    initial begin
        logic [RD_MAX-1:0][31:0] vv;
        bus.eei_req = 1'b0;
        scramble_core();
        bus.ch_ack    = '0;
        bus.ch_error  = '0;
        bus.ch_rd_op  = '0;
        bus.ch_rd_len = '0;
        bus.ch_rd_val = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", RW'(bus.eei_ack), RW'(0));
        chk("reset_results", {bus.eei_error, bus.eei_rd_op, bus.eei_rd_len, bus.eei_rd_val}, RW'(0));
        chk("reset_ch_req", RW'(bus.ch_req), RW'(0));
        chk("reset_ch_operands", RW'({bus.ch_funct7, bus.ch_batch_start, bus.ch_batch_len, bus.ch_rs_val}), RW'(0));
        chk("reset_state", RW'(dbg_state), RW'(0));
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < RD_MAX; i++) vv[i] = $urandom;
        vv[0] = 32'hDEADBEEF;
        run_instr(4'd1, 0, 1'b0, 2'd1, 5'd7, vv, 1'b0);
        run_instr(4'd9, 0, 1'b0, 2'd1, 5'd0, vv, 1'b0);
        vv = {32'h5555_AAAA, 32'd3, 32'd2, 32'd1};
        run_instr(4'd2, 5, 1'b0, 2'd2, 5'd3, vv, 1'b0);
        run_instr(4'd3, 1, 1'b0, 2'd2, 5'd5, vv, 1'b0);
        run_instr(4'd0, 0, 1'b0, 2'd2, 5'd4, vv, 1'b0);
        run_instr(4'd0, 2, 1'b0, 2'd2, 5'd0, vv, 1'b0);
        run_instr(4'd1, 0, 1'b0, 2'd3, 5'd2, vv, 1'b0);
        run_instr(4'd2, 3, 1'b1, 2'd1, 5'd2, vv, 1'b0);
        run_instr(4'd3, 0, 1'b0, 2'd0, 5'd9, vv, 1'b0);
        run_instr(4'd15, 0, 1'b0, 2'd0, 5'd0, vv, 1'b0);

`ifdef SOPHON_EEI_TIMEOUT_EN
        run_instr(4'd2, 1000, 1'b0, 2'd1, 5'd0, vv, 1'b1);
        bus.ch_ack = '1;
        repeat (4) @(posedge clk);
        #1;
        bus.ch_ack = '0;
        run_instr(4'd1, TMO - 1, 1'b0, 2'd1, 5'd0, vv, 1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [3:0] ridx;
            ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            for (int i = 0; i < RD_MAX; i++) vv[i] = $urandom;
            run_instr(ridx, $urandom_range(0, 6), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 6)), vv, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        // Reset while a unit request is outstanding.
        bus.ch_ack     = '0;
        bus.eei_req    = 1'b1;
        bus.eei_ext    = 1'b0;
        bus.eei_funct3 = 3'd1;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", RW'(bus.ch_req), RW'(4'b0010));
        rst_ni = 1'b0;
        #1;
        chk("midrst_ch_req", RW'(bus.ch_req), RW'(0));
        chk("midrst_ack", RW'(bus.eei_ack), RW'(0));
        chk("midrst_state", RW'(dbg_state), RW'(0));
        bus.eei_req = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        vv = {32'd0, 32'd0, 32'd0, 32'h1234_5678};
        run_instr(4'd1, 2, 1'b0, 2'd1, 5'd0, vv, 1'b0);

        repeat (4) @(posedge clk);
        chk("queue_drained", RW'(exp_q.size()), RW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
